// File: rtl/spi_rx_pkg.sv
// Shared constants and state type for the SPI frame receiver and the
// downstream address decoder that consumes its words.
package spi_rx_pkg;

    localparam int FRAME_BITS_DEFAULT = 16;

    // Frame field layout, also used by the decoder.
    localparam int ADDR_MSB    = 15;
    localparam int ADDR_LSB    = 12;
    localparam int PAYLOAD_MSB = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } rx_state_t;

endpackage

// File: rtl/spi_frame_receiver_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, plus one further delayed
// flop so rising/falling edges of the synchronized level can be detected.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stage_reg;
    logic                   delayed_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_reg   <= {SYNC_STAGES{RESET_VAL}};
            delayed_reg <= RESET_VAL;
        end else begin
            stage_reg   <= {stage_reg[SYNC_STAGES-2:0], din};
            delayed_reg <= stage_reg[SYNC_STAGES-1];
        end
    end

    assign level = stage_reg[SYNC_STAGES-1];
    assign rise  = level & ~delayed_reg;
    assign fall  = ~level & delayed_reg;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI slave (CPOL=0, CPHA=0) that deserializes fixed-length frames into the
// clk domain and hands each word out through a one-entry valid/ready buffer.
module spi_frame_receiver
    import spi_rx_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_sck,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_err,
    output logic                  overrun,
    input  logic                  overrun_clr,
    output logic                  busy
);

    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    logic sck_level_unused, sck_rise, sck_fall_unused;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .din(spi_sck),
        .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk(clk), .rst(rst), .din(spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi (
        .clk(clk), .rst(rst), .din(spi_mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    rx_state_t              state_reg, state_next;
    logic [CNT_W-1:0]       bit_cnt_reg;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic                   long_frame_reg;
    logic [SYNC_STAGES:0]   settle_reg;
    logic                   armed_reg;
    logic [FRAME_BITS-1:0]  data_reg;
    logic                   valid_reg;
    logic                   err_reg;
    logic                   overrun_reg;

    logic                   start, shift_en, word_done, err_next;
    logic                   long_set, long_clr, overrun_set;
    logic [FRAME_BITS-1:0]  done_word;

    assign done_word   = {shift_reg[FRAME_BITS-2:0], mosi_level};
    assign overrun_set = word_done & valid_reg & ~frame_ready;

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        err_next   = 1'b0;
        long_set   = 1'b0;
        long_clr   = 1'b0;
        case (state_reg)
            IDLE: begin
                // Only a genuine falling edge seen after cs_n was high starts a frame.
                if (cs_fall && armed_reg) begin
                    start      = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    err_next   = (bit_cnt_reg != '0);
                    state_next = IDLE;
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                    if (bit_cnt_reg == LAST_BIT) begin
                        word_done  = 1'b1;
                        state_next = WAIT_CS;
                    end
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    err_next   = long_frame_reg;
                    long_clr   = 1'b1;
                    state_next = IDLE;
                end else if (sck_rise) begin
                    long_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            long_frame_reg <= 1'b0;
            settle_reg     <= '0;
            armed_reg      <= 1'b0;
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            err_reg        <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            err_reg    <= err_next;
            // The synchronizer holds reset levels until refilled with real pin samples.
            settle_reg <= {settle_reg[SYNC_STAGES-1:0], 1'b1};
            if (settle_reg[SYNC_STAGES] && cs_level) armed_reg <= 1'b1;

            if (start) begin
                bit_cnt_reg <= '0;
                shift_reg   <= '0;
            end else if (shift_en) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                shift_reg   <= done_word;
            end

            if (long_clr)      long_frame_reg <= 1'b0;
            else if (long_set) long_frame_reg <= 1'b1;

            if (word_done) begin
                if (!valid_reg || frame_ready) begin
                    data_reg  <= done_word;
                    valid_reg <= 1'b1;
                end
            end else if (valid_reg && frame_ready) begin
                valid_reg <= 1'b0;
            end

            if (overrun_set)      overrun_reg <= 1'b1;
            else if (overrun_clr) overrun_reg <= 1'b0;
        end
    end

    assign frame_data  = data_reg;
    assign frame_valid = valid_reg;
    assign frame_err   = err_reg;
    assign overrun     = overrun_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: directed scenarios plus random
// frames of random length, checked against a bit-list frame model.
module tb_spi_frame_receiver;

    logic        clk = 1'b0;
    logic        rst, spi_sck, spi_cs_n, spi_mosi;
    logic [15:0] frame_data;
    logic        frame_valid, frame_ready, frame_err, overrun, overrun_clr, busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] got_q[$];
    int          err_cycles   = 0;
    int          valid_cycles = 0;

    spi_frame_receiver #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .frame_err(frame_err), .overrun(overrun),
        .overrun_clr(overrun_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Monitor: record accepted words and pulse widths, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid && frame_ready) got_q.push_back(frame_data);
            if (frame_err)   err_cycles++;
            if (frame_valid) valid_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_q.delete();
        err_cycles   = 0;
        valid_cycles = 0;
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(4);
        spi_cs_n = 1'b1;
        tick(8);
    endtask

    // sck half period of 4 clk cycles; bits sent MSB first from bits[n-1].
    task automatic clock_bits(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = bits[i];
            tick(4);
            spi_sck = 1'b1;
            tick(4);
            spi_sck = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        $display("frame n=%0d bits=0x%0h ready=%0b", n, bits, frame_ready);
        cs_low();
        clock_bits(bits, n);
        cs_high();
    endtask

    task automatic test_reset();
        rst = 1'b1; spi_sck = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
        frame_ready = 1'b0; overrun_clr = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(10);
        total++; if (frame_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", frame_data); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", frame_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        clear_log();
        frame_ready = 1'b1;
        $display("frame n=16 bits=0x3a5c ready=1");
        cs_low();
        clock_bits(32'h3A5C, 16);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
        cs_high();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", busy); end
        total++; if (got_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
        else begin
            total++; if (got_q[0] !== 16'h3A5C) begin bad++; $display("FAIL single_data got=%h exp=3a5c", got_q[0]); end
        end
        total++; if (valid_cycles !== 1) begin bad++; $display("FAIL single_valid_cycles got=%0d exp=1", valid_cycles); end
        total++; if (err_cycles !== 0) begin bad++; $display("FAIL single_err got=%0d exp=0", err_cycles); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL single_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_hold();
        clear_log();
        frame_ready = 1'b0;
        send_frame(32'h8003, 16);
        tick(50);
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", frame_valid); end
        total++; if (frame_data !== 16'h8003) begin bad++; $display("FAIL hold_data got=%h exp=8003", frame_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL hold_busy got=%b exp=0", busy); end
        frame_ready = 1'b1;
        tick(1);
        frame_ready = 1'b0;
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL hold_release got=%b exp=0", frame_valid); end
        total++; if (got_q.size() !== 1 || got_q[0] !== 16'h8003) begin
            bad++; $display("FAIL hold_accept got_n=%0d exp_n=1 exp=8003", got_q.size());
        end
    endtask

    task automatic test_overrun();
        clear_log();
        frame_ready = 1'b0;
        send_frame(32'h1111, 16);
        send_frame(32'h2222, 16);
        total++; if (frame_data !== 16'h1111) begin bad++; $display("FAIL ovr_data got=%h exp=1111", frame_data); end
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
        overrun_clr = 1'b1;
        tick(1);
        overrun_clr = 1'b0;
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
        frame_ready = 1'b1;
        tick(3);
        total++; if (got_q.size() !== 1 || got_q[0] !== 16'h1111) begin
            bad++; $display("FAIL ovr_drain got_n=%0d exp_n=1 exp=1111", got_q.size());
        end
    endtask

    task automatic test_short_long();
        logic [31:0] bits;
        clear_log();
        frame_ready = 1'b1;
        bits = $urandom & 32'h1FF;
        send_frame(bits, 9);
        total++; if (err_cycles !== 1) begin bad++; $display("FAIL short_err got=%0d exp=1", err_cycles); end
        total++; if (valid_cycles !== 0) begin bad++; $display("FAIL short_valid got=%0d exp=0", valid_cycles); end
        clear_log();
        bits = $urandom & 32'h3FFFF;
        send_frame(bits, 18);
        total++; if (err_cycles !== 1) begin bad++; $display("FAIL long_err got=%0d exp=1", err_cycles); end
        total++; if (got_q.size() !== 1 || got_q[0] !== 16'(bits >> 2)) begin
            bad++; $display("FAIL long_data got_n=%0d exp=%h", got_q.size(), 16'(bits >> 2));
        end
    endtask

    task automatic test_reset_midframe();
        clear_log();
        frame_ready = 1'b1;
        $display("frame n=8+rst+8 ready=1");
        cs_low();
        clock_bits($urandom, 8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        clock_bits($urandom, 8);
        cs_high();
        total++; if (valid_cycles !== 0) begin bad++; $display("FAIL rstmid_valid got=%0d exp=0", valid_cycles); end
        total++; if (err_cycles !== 0) begin bad++; $display("FAIL rstmid_err got=%0d exp=0", err_cycles); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        send_frame(32'h7FFF, 16);
        total++; if (got_q.size() !== 1 || got_q[0] !== 16'h7FFF) begin
            bad++; $display("FAIL rstmid_next got_n=%0d exp=7fff", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        frame_ready = 1'b0;
        send_frame(32'h0001, 16);
        $display("frame n=16 bits=0x2 ready=late");
        cs_low();
        clock_bits(32'h0001, 15);
        spi_mosi = 1'b0;
        tick(4);
        spi_sck = 1'b1;
        // Raise ready so the handshake lands on the completion cycle.
        tick(2);
        frame_ready = 1'b1;
        tick(1);
        total++; if (frame_valid !== 1'b1 || frame_data !== 16'h0002) begin
            bad++; $display("FAIL b2b_load valid=%b data=%h exp=1/0002", frame_valid, frame_data);
        end
        tick(3);
        spi_sck = 1'b0;
        cs_high();
        total++; if (got_q.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", got_q.size()); end
        else begin
            total++; if (got_q[0] !== 16'h0001 || got_q[1] !== 16'h0002) begin
                bad++; $display("FAIL b2b_order got=%h,%h exp=0001,0002", got_q[0], got_q[1]);
            end
        end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    endtask

    task automatic test_random();
        logic [31:0] bits;
        int          n;
        frame_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            clear_log();
            n    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(10, 20)) : 16;
            bits = $urandom & ((32'h1 << n) - 1);
            send_frame(bits, n);
            // Reference: first 16 bits form the word if at least 16 arrived; any length but 16 is an error.
            total++; if (err_cycles !== ((n != 16) ? 1 : 0)) begin
                bad++; $display("FAIL rand_err n=%0d got=%0d exp=%0d", n, err_cycles, (n != 16) ? 1 : 0);
            end
            total++; if (got_q.size() !== ((n >= 16) ? 1 : 0)) begin
                bad++; $display("FAIL rand_count n=%0d got=%0d", n, got_q.size());
            end else if (n >= 16) begin
                total++; if (got_q[0] !== 16'(bits >> (n - 16))) begin
                    bad++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, got_q[0], 16'(bits >> (n - 16)));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold();
        test_overrun();
        test_short_long();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
